synchronizer: RTL and testbench
===============================

SYNCHRONIZER -- requirements
Module: synchronizer

Interface
- REQ-001: Parameter WIDTH, default 3; data bus is WIDTH+1 bits, [WIDTH:0]; first positional parameter; SHALL be >= 0.
- REQ-002: Parameter STAGES, default 2; number of flip-flop stages in the synchronizing chain; SHALL be >= 2, with elaboration error if smaller.
- REQ-003: Port clk, input, 1 bit; destination-domain clock; all state SHALL update on its rising edge.
- REQ-004: Port rst, input, 1 bit; asynchronous, active-low reset (0 = reset asserted).
- REQ-005: Port d_in, input, [WIDTH:0]; data from a foreign clock domain, asynchronous to clk.
- REQ-006: Port d_out, output, [WIDTH:0]; synchronized copy of d_in, driven directly from the final stage register.

Function
- REQ-007: Each bit of d_in SHALL pass through an independent chain of STAGES flip-flops clocked by clk; no combinational logic between stages or on d_out.
- REQ-008: Latency: a d_in value stable across rising edge N SHALL appear on d_out immediately after rising edge N+STAGES-1, i.e. STAGES edges after the d_in change (2 edges at default).
- REQ-009: A d_in value held for only one clk period SHALL still propagate, delayed, when sampled cleanly; no filtering or debouncing.
- REQ-010: The block SHALL NOT guarantee multi-bit coherence; callers SHALL feed Gray-coded or otherwise single-bit-change data, such as FIFO pointers.
- REQ-011: d_out SHALL hold its value between edges and SHALL NOT change on d_in transitions without a clk edge.
- REQ-012: Stage registers SHALL carry a synthesis attribute marking them as asynchronous registers (ASYNC_REG or equivalent) and SHALL be excluded from retiming.

Reset
- REQ-013: While rst = 0, every stage register and d_out SHALL be 0, without waiting for a clk edge.
- REQ-014: On rst deassertion, the chain SHALL resume at the next rising edge; d_out SHALL reflect d_in no earlier than STAGES edges after release.
- REQ-015: Reset asserted mid-transfer SHALL clear all in-flight data immediately; no stale value SHALL emerge after release.

Structure
- REQ-016: WIDTH and STAGES defaults SHALL be defined as constants in a shared package, fifo_pkg, and reused by the async-FIFO pointer paths.
- REQ-017: Implementation SHALL use one sub-module, sync_cell, a 1-bit STAGES-deep chain with async active-low reset, instantiated WIDTH+1 times via generate.

Verification
Bench clk period 10 ns, first rising edge at 5 ns; rst = 0 until 12 ns.
- REQ-018: Reset hold: during 0–12 ns, d_out SHALL equal 0 whatever d_in does, including mid-reset changes.
- REQ-019: Latency: d_in = 5 at 22 ns -> d_out = 0 until 35 ns, then d_out = 5 after the 35 ns edge (2-edge latency).
- REQ-020: Streaming: d_in = 6, 7, 8, 9 at 32, 42, 52, 62 ns -> d_out = 6, 7, 8, 9 after the 45, 55, 65, 75 ns edges respectively; 8 and 9 SHALL exercise the MSB at WIDTH = 3.
- REQ-021: Async reset mid-stream: drive rst = 0 between edges while d_out = 9 -> d_out = 0 immediately; after release with d_in = 9 -> d_out = 9 after 2 edges.
- REQ-022: Parameter sweep: STAGES = 3, WIDTH = 7, d_in = 0xA5 -> d_out = 0xA5 exactly 3 edges later; STAGES = 1 SHALL fail elaboration.

Source files
------------

// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared constants for the clock-domain-crossing pieces of the async FIFO.
// The pointer synchronizers and the FIFO pointer paths both size themselves
// from these, so a change here keeps them consistent.
// -----------------------------------------------------------------------------
package fifo_pkg;

    // Pointer bus is SYNC_WIDTH+1 bits ([SYNC_WIDTH:0]).
    localparam int SYNC_WIDTH      = 3;
    // Flops in each synchronizing chain.
    localparam int SYNC_STAGES     = 2;
    // Fewer than two flops gives no metastability settling time.
    localparam int SYNC_MIN_STAGES = 2;

endpackage : fifo_pkg

// File: rtl/sync_cell.sv
// -----------------------------------------------------------------------------
// sync_cell
// One-bit, STAGES-deep flip-flop chain used to bring a single asynchronous
// bit into the clk domain. There is no logic between stages.
//
// Ports:
//   clk  - destination-domain clock, rising edge
//   rst  - asynchronous reset, active low; clears every stage immediately
//   d    - asynchronous input bit
//   q    - synchronized bit, taken straight from the last stage flop
// -----------------------------------------------------------------------------
module sync_cell
    import fifo_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    generate
        if (STAGES < SYNC_MIN_STAGES) begin : g_bad_stages
            $error("sync_cell: STAGES must be >= 2");
        end
    endgenerate

    // Keep the chain together in placement and out of retiming so the
    // settling time between flops is preserved.
    (* ASYNC_REG = "TRUE", DONT_TOUCH = "TRUE", syn_preserve = 1 *)
    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Bit 0 samples the async input; each later bit samples its neighbour.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule : sync_cell

// File: rtl/synchronizer.sv
// -----------------------------------------------------------------------------
// synchronizer
// Multi-bit CDC synchronizer: every bit of d_in gets its own sync_cell chain.
// Bits are NOT kept coherent with each other; feed it Gray-coded or otherwise
// single-bit-change data (e.g. async FIFO pointers).
//
// Ports:
//   clk    - destination-domain clock, rising edge
//   rst    - asynchronous reset, active low
//   d_in   - [WIDTH:0] data from a foreign clock domain
//   d_out  - [WIDTH:0] synchronized data, STAGES edges behind d_in
// -----------------------------------------------------------------------------
module synchronizer
    import fifo_pkg::*;
#(
    parameter int WIDTH  = SYNC_WIDTH,
    parameter int STAGES = SYNC_STAGES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [WIDTH:0] d_in,
    output logic [WIDTH:0] d_out
);

    generate
        if (WIDTH < 0) begin : g_bad_width
            $error("synchronizer: WIDTH must be >= 0");
        end

        for (genvar i = 0; i <= WIDTH; i++) begin : g_bit
            sync_cell #(
                .STAGES (STAGES)
            ) u_sync_cell (
                .clk (clk),
                .rst (rst),
                .d   (d_in[i]),
                .q   (d_out[i])
            );
        end
    endgenerate

endmodule : synchronizer

// File: tb/tb_synchronizer.sv
// -----------------------------------------------------------------------------
// tb_synchronizer
// Directed bench: default instance (WIDTH=3, STAGES=2) plus a WIDTH=7,
// STAGES=3 instance sharing clock and reset. clk period 10 ns, first rising
// edge at 5 ns, rst low until 12 ns. Checks are taken between edges.
// -----------------------------------------------------------------------------
module tb_synchronizer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] d_in = 4'h0;
    logic [3:0] d_out;
    logic [7:0] d_in_w = 8'h00;
    logic [7:0] d_out_w;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    synchronizer u_dut (
        .clk   (clk),
        .rst   (rst),
        .d_in  (d_in),
        .d_out (d_out)
    );

    synchronizer #(
        .WIDTH  (7),
        .STAGES (3)
    ) u_dut_w (
        .clk   (clk),
        .rst   (rst),
        .d_in  (d_in_w),
        .d_out (d_out_w)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic at(input int t);
        if ($time < t) #(t - $time);
    endtask

    initial begin
        // Reset hold, including a mid-reset d_in change
        at(1);   chk("rst_out",        32'(d_out),   32'h0);
                 chk("rst_out_w",      32'(d_out_w), 32'h0);
        at(3);   d_in = 4'hF;
        at(7);   chk("rst_after_edge", 32'(d_out),   32'h0);
        at(8);   d_in = 4'h0;
        at(12);  rst = 1'b1;

        // Two-edge latency
        at(22);  d_in = 4'h5;
        at(26);  chk("lat_one_edge",   32'(d_out), 32'h0);
        at(30);  chk("lat_pre35",      32'(d_out), 32'h0);
        at(32);  d_in = 4'h6;
        at(36);  chk("lat_5",          32'(d_out), 32'h5);

        // Streaming, 8 and 9 hit the MSB
        at(40);  chk("hold_5",         32'(d_out), 32'h5);
        at(42);  d_in = 4'h7;
        at(46);  chk("stream_6",       32'(d_out), 32'h6);
        at(52);  d_in = 4'h8;
        at(56);  chk("stream_7",       32'(d_out), 32'h7);
        at(62);  d_in = 4'h9;
        at(66);  chk("stream_8",       32'(d_out), 32'h8);
        at(76);  chk("stream_9",       32'(d_out), 32'h9);

        // Async reset between edges while d_out = 9
        at(78);  rst = 1'b0;
        at(79);  chk("async_rst",      32'(d_out), 32'h0);
        at(86);  chk("rst_held",       32'(d_out), 32'h0);
        at(88);  rst = 1'b1;
        at(96);  chk("rel_one_edge",   32'(d_out), 32'h0);
        at(106); chk("rel_9",          32'(d_out), 32'h9);

        // d_in change without a clock edge leaves d_out alone
        at(108); d_in = 4'h3;
        at(110); chk("no_edge_hold",   32'(d_out), 32'h9);

        // Wide / 3-stage instance
        at(112); d_in_w = 8'hA5;
        at(116); chk("w_edge1",        32'(d_out_w), 32'h0);
        at(126); chk("w_edge2",        32'(d_out_w), 32'h0);
                 chk("val_3",          32'(d_out),   32'h3);
        // Single-period pulse still propagates
        at(132); d_in = 4'hC;
        at(136); chk("w_a5",           32'(d_out_w), 32'hA5);
        at(142); d_in = 4'h3;
        at(146); chk("pulse_c",        32'(d_out), 32'hC);
        at(156); chk("pulse_back_3",   32'(d_out), 32'h3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_synchronizer
